// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: symbol width, default amplitude, mapper FSM states and the bit->symbol map.
// Used by both the modulator and the demapper so that symbol widths always agree.
package bpsk_pkg;

  localparam int SYM_W = 11;
  localparam logic signed [SYM_W-1:0] AMP_DEFAULT = 11'sd511;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Inverse of the hard decision: 1 -> +amp, 0 -> -amp
  function automatic logic signed [SYM_W-1:0] map(input logic b,
                                                  input logic signed [SYM_W-1:0] amp);
    return b ? amp : -amp;
  endfunction

endpackage

// File: rtl/bpsk_sym_map.sv
// Registered bit -> (ar, ai) mapper; valid passes through one register stage and both
// symbol rails are forced to zero whenever the symbol is not valid.
module bpsk_sym_map
  import bpsk_pkg::*;
#(
  parameter logic signed [SYM_W-1:0] AMP = AMP_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld_p0,
  input  logic                    sym_p0,
  output logic                    vld_p1,
  output logic signed [SYM_W-1:0] ar,
  output logic signed [SYM_W-1:0] ai
);

  // p0 -> p1: symbol register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      ar     <= '0;
      ai     <= '0;
    end else begin
      vld_p1 <= vld_p0;
      ar     <= vld_p0 ? map(sym_p0, AMP) : '0;
      ai     <= '0;
    end
  end

endmodule

// File: rtl/bpsk_mod.sv
// BPSK transmit mapper: byte handshake, MSB-first serialiser, SPS clocks per symbol.
// Optional differential encoding is enabled by defining BPSK_MOD_DIFF_EN.
module bpsk_mod
  import bpsk_pkg::*;
#(
  parameter logic signed [SYM_W-1:0] AMP = AMP_DEFAULT,
  parameter int                      SPS = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    valid_d,
  input  logic [7:0]              d,
  output logic                    ready_d,
  output logic                    valid_i,
  output logic signed [SYM_W-1:0] ar,
  output logic signed [SYM_W-1:0] ai
);

  localparam logic [7:0] SMP_LAST = 8'(SPS - 1);

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] smp_cnt, smp_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       sym_last;
  logic       accept;
  logic       vld_p0;
  logic       sym_p0;
  logic       enc_p0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      smp_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      smp_cnt <= smp_cnt_n;
      shreg   <= shreg_n;
    end
  end

  // Next-state values also drive the mapper so the symbol appears in the same cycle
  // as the counters that describe it (registered outputs, no extra latency).
  always_comb begin
    sym_last  = (smp_cnt == SMP_LAST);
    ready_d   = (state == IDLE) || ((state == SEND) && (bit_cnt == 3'd7) && sym_last);
    accept    = valid_d && ready_d;
    state_n   = state;
    bit_cnt_n = bit_cnt;
    smp_cnt_n = smp_cnt;
    shreg_n   = shreg;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = SEND;
          shreg_n   = d;
          bit_cnt_n = '0;
          smp_cnt_n = '0;
        end
      end
      SEND: begin
        if (!sym_last) begin
          smp_cnt_n = smp_cnt + 8'd1;
        end else begin
          smp_cnt_n = '0;
          if (bit_cnt != 3'd7) begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = {shreg[6:0], 1'b0};
          end else if (accept) begin
            shreg_n   = d;
            bit_cnt_n = '0;
          end else begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            shreg_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    vld_p0 = (state_n == SEND) && (smp_cnt_n == 8'd0);
    sym_p0 = shreg_n[7];
  end

`ifdef BPSK_MOD_DIFF_EN
  logic t_q;
  logic t_n;

  assign t_n    = sym_p0 ^ t_q;
  assign enc_p0 = t_n;

  // Encoder history survives IDLE gaps; only reset clears it
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      t_q <= 1'b1;
    end else if (vld_p0) begin
      t_q <= t_n;
    end
  end
`else
  assign enc_p0 = sym_p0;
`endif

  bpsk_sym_map #(
    .AMP(AMP)
  ) u_sym_map (
    .clk   (CLK),
    .rst_n (RST),
    .vld_p0(vld_p0),
    .sym_p0(enc_p0),
    .vld_p1(valid_i),
    .ar    (ar),
    .ai    (ai)
  );

endmodule

// File: tb/tb_bpsk_mod.sv
// Bench for bpsk_mod: two instances (SPS=1 and SPS=4) checked every cycle against a
// cycle-indexed symbol schedule built from each accepted byte.
module tb_bpsk_mod;
  import bpsk_pkg::*;

  localparam int AMP   = 511;
  localparam int SPS_A = 1;
  localparam int SPS_B = 4;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b0;
  logic                    valid_d [2];
  logic [7:0]              d       [2];
  logic                    ready_d [2];
  logic                    valid_i [2];
  logic signed [SYM_W-1:0] ar      [2];
  logic signed [SYM_W-1:0] ai      [2];

  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  int   exp_ar[int];
  int   busy_end[2];
  int   acc_evt[2];
  logic t_st[2];
  int   cap0[$];
  int   cap1[$];

  bpsk_mod #(.AMP(11'sd511), .SPS(SPS_A)) dut_a (
    .CLK(CLK), .RST(RST), .valid_d(valid_d[0]), .d(d[0]), .ready_d(ready_d[0]),
    .valid_i(valid_i[0]), .ar(ar[0]), .ai(ai[0]));

  bpsk_mod #(.AMP(11'sd511), .SPS(SPS_B)) dut_b (
    .CLK(CLK), .RST(RST), .valid_d(valid_d[1]), .d(d[1]), .ready_d(ready_d[1]),
    .valid_i(valid_i[1]), .ar(ar[1]), .ai(ai[1]));

  always #5 CLK = ~CLK;

  function automatic int sps_of(input int i);
    return (i == 0) ? SPS_A : SPS_B;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Accepted byte v at edge cyc: bit 7-k goes out in cycle cyc + k*SPS
  task automatic schedule(input int i, input logic [7:0] v);
    int   s;
    logic b;
    s = sps_of(i);
    busy_end[i] = cyc + 8 * s - 1;
    for (int k = 0; k < 8; k++) begin
      b = v[7-k];
`ifdef BPSK_MOD_DIFF_EN
      t_st[i] = b ^ t_st[i];
      b = t_st[i];
`endif
      exp_ar[(cyc + k * s) * 2 + i] = b ? AMP : -AMP;
    end
  endtask

  always @(posedge CLK) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      acc_evt[i] = 0;
      if (RST && valid_d[i] && (cyc - 1 >= busy_end[i])) begin
        acc_evt[i] = 1;
        schedule(i, d[i]);
      end
    end
  end

  always @(negedge RST) begin
    exp_ar.delete();
    for (int i = 0; i < 2; i++) begin
      busy_end[i] = 0;
      t_st[i]     = 1'b1;
    end
  end

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      int key;
      int ev;
      int ea;
      key = cyc * 2 + i;
      ev  = exp_ar.exists(key) ? 1 : 0;
      ea  = ev ? exp_ar[key] : 0;
      if (ev != 0) exp_ar.delete(key);
      chk($sformatf("sps%0d_valid_i", sps_of(i)), int'(valid_i[i]), ev);
      chk($sformatf("sps%0d_ar", sps_of(i)), int'(ar[i]), ea);
      chk($sformatf("sps%0d_ai", sps_of(i)), int'(ai[i]), 0);
      chk($sformatf("sps%0d_ready_d", sps_of(i)), int'(ready_d[i]), (cyc >= busy_end[i]) ? 1 : 0);
      if (valid_i[i]) begin
        if (i == 0) cap0.push_back(int'(ar[i]));
        else        cap1.push_back(int'(ar[i]));
      end
    end
  end

  task automatic send(input int i, input logic [7:0] v, input bit hold);
    int w;
    valid_d[i] = 1'b1;
    d[i]       = v;
    w          = 0;
    do begin
      @(posedge CLK);
      #1;
      w++;
    end while (acc_evt[i] == 0 && w < 300);
    chk($sformatf("sps%0d_accept", sps_of(i)), acc_evt[i], 1);
    if (!hold) valid_d[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic chk_cap(input string tag, input int q[$], input int expv[$]);
    chk({tag, "_count"}, q.size(), expv.size());
    for (int k = 0; k < expv.size() && k < q.size(); k++)
      chk($sformatf("%s_sym%0d", tag, k), q[k], expv[k]);
  endtask

  initial begin
    int ref_q[$];
    for (int i = 0; i < 2; i++) begin
      valid_d[i]  = 1'b0;
      d[i]        = 8'h00;
      busy_end[i] = 0;
      acc_evt[i]  = 0;
      t_st[i]     = 1'b1;
    end
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #2 RST = 1'b1;
    idle(2);

`ifdef BPSK_MOD_DIFF_EN
    cap0.delete();
    send(0, 8'h00, 1);
    send(0, 8'hFF, 0);
    idle(20);
    ref_q = '{511, 511, 511, 511, 511, 511, 511, 511,
              -511, 511, -511, 511, -511, 511, -511, 511};
    chk_cap("diff_00_ff", cap0, ref_q);
`endif

    cap0.delete();
    send(0, 8'hA5, 0);
    idle(12);
`ifndef BPSK_MOD_DIFF_EN
    ref_q = '{511, -511, 511, -511, -511, 511, -511, 511};
    chk_cap("a5", cap0, ref_q);
`endif

    cap0.delete();
    send(0, 8'hFF, 1);
    send(0, 8'h00, 0);
    idle(20);
`ifndef BPSK_MOD_DIFF_EN
    ref_q = '{511, 511, 511, 511, 511, 511, 511, 511,
              -511, -511, -511, -511, -511, -511, -511, -511};
    chk_cap("ff_00", cap0, ref_q);
`endif

    cap1.delete();
    send(1, 8'h80, 0);
    idle(40);
`ifndef BPSK_MOD_DIFF_EN
    ref_q = '{511, -511, -511, -511, -511, -511, -511, -511};
    chk_cap("sps4_80", cap1, ref_q);
`endif

    // Reset during the third symbol of 0xF0
    send(0, 8'hF0, 0);
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("rst_valid_i", int'(valid_i[0]), 0);
    chk("rst_ar", int'(ar[0]), 0);
    chk("rst_ready_d", int'(ready_d[0]), 1);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    cap0.delete();
    send(0, 8'hF0, 0);
    idle(12);
`ifndef BPSK_MOD_DIFF_EN
    ref_q = '{511, 511, 511, 511, -511, -511, -511, -511};
    chk_cap("f0_after_rst", cap0, ref_q);
`endif

    repeat (1500) begin
      @(posedge CLK);
      #2;
      RST = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < 2; i++) begin
        valid_d[i] = ($urandom_range(0, 3) != 0);
        d[i]       = 8'($urandom);
      end
    end
    @(posedge CLK);
    #2;
    RST = 1'b1;
    valid_d[0] = 1'b0;
    valid_d[1] = 1'b0;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
